// File: rtl/maxnet.sv
// Four-neuron Maxnet winner-take-all network: lateral inhibition from parameter
// activations until at most one neuron stays non-zero or the iteration cap is hit.
module maxnet #(
   parameter logic [15:0] A0       = 16'd51,
   parameter logic [15:0] A1       = 16'd102,
   parameter logic [15:0] A2       = 16'd154,
   parameter logic [15:0] A3       = 16'd205,
   parameter logic [7:0]  EPS      = 8'd51,
   parameter logic [7:0]  MAX_ITER = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        ready,
   output logic [1:0]  winner,
   output logic [15:0] winner_value
);

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

   state_t             state_q, state_d;
   logic [3:0][15:0]   a_q, a_d;
   logic [7:0]         iter_q, iter_d;
   logic               ready_q, ready_d;
   logic [1:0]         winner_q, winner_d;
   logic [15:0]        wval_q, wval_d;

   logic [17:0]        total_s;
   logic [3:0][17:0]   sum_oth_s;
   logic [3:0][25:0]   prod_s;
   logic [3:0][25:0]   dec_s;
   logic [3:0][15:0]   upd_s;
   logic [2:0]         nz_s;
   logic [1:0]         best_idx_s;
   logic [15:0]        best_val_s;
   logic [7:0]         iter_nxt_s;
   logic               converge_s;

   // one parallel inhibition step from the current activations, plus convergence and argmax
   always_comb begin
      total_s    = {2'd0, a_q[0]} + {2'd0, a_q[1]} + {2'd0, a_q[2]} + {2'd0, a_q[3]};
      sum_oth_s  = '0;
      prod_s     = '0;
      dec_s      = '0;
      upd_s      = '0;
      nz_s       = 3'd0;
      best_idx_s = 2'd0;
      best_val_s = 16'd0;
      for (int j = 0; j < 4; j++) begin
         sum_oth_s[j] = total_s - {2'd0, a_q[j]};
         prod_s[j]    = {18'd0, EPS} * {8'd0, sum_oth_s[j]};
         dec_s[j]     = prod_s[j] >> 8;
         if ({10'd0, a_q[j]} >= dec_s[j]) begin
            upd_s[j] = a_q[j] - dec_s[j][15:0];
         end else begin
            upd_s[j] = 16'd0;
         end
         if (upd_s[j] != 16'd0) begin
            nz_s = nz_s + 3'd1;
         end else begin
            nz_s = nz_s;
         end
         // strict compare keeps the lowest index on equal maxima
         if (upd_s[j] > best_val_s) begin
            best_idx_s = j[1:0];
            best_val_s = upd_s[j];
         end else begin
            best_idx_s = best_idx_s;
         end
      end
      iter_nxt_s = iter_q + 8'd1;
      converge_s = (nz_s <= 3'd1) || (iter_nxt_s == MAX_ITER);
   end

   // next-state and result logic
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      iter_d   = iter_q;
      ready_d  = ready_q;
      winner_d = winner_q;
      wval_d   = wval_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            a_d     = {A3, A2, A1, A0};
            iter_d  = 8'd0;
            ready_d = 1'b0;
            state_d = ITER;
         end
         ITER: begin
            a_d    = upd_s;
            iter_d = iter_nxt_s;
            if (converge_s) begin
               state_d  = DONE;
               ready_d  = 1'b1;
               winner_d = best_idx_s;
               wval_d   = best_val_s;
            end else begin
               state_d  = ITER;
            end
         end
         DONE: begin
            if (start) begin
               state_d = LOAD;
               ready_d = 1'b0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b0;
         end
      endcase
   end

   // state and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         iter_q   <= 8'd0;
         ready_q  <= 1'b0;
         winner_q <= 2'd0;
         wval_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         iter_q   <= iter_d;
         ready_q  <= ready_d;
         winner_q <= winner_d;
         wval_q   <= wval_d;
      end
   end

   assign ready        = ready_q;
   assign winner       = winner_q;
   assign winner_value = wval_q;

endmodule

// File: tb/tb_maxnet.sv
// Self-checking bench for maxnet: four parameter variants driven with randomized
// start timing and spurious starts, checked against an arithmetic reference model.
module tb_maxnet;

   localparam int NI = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [NI-1:0]       start;
   logic [NI-1:0]       rdy;
   logic [NI-1:0][1:0]  win;
   logic [NI-1:0][15:0] wv;

   int checks   = 0;
   int failures = 0;
   int exp_n [NI];
   int exp_w [NI];
   int exp_v [NI];

   always #5 clk = ~clk;

   maxnet u_def (.clk(clk), .rst(rst), .start(start[0]), .ready(rdy[0]), .winner(win[0]), .winner_value(wv[0]));
   maxnet #(.A0(16'd205), .A1(16'd205), .A2(16'd0), .A3(16'd0)) u_tie
      (.clk(clk), .rst(rst), .start(start[1]), .ready(rdy[1]), .winner(win[1]), .winner_value(wv[1]));
   maxnet #(.A0(16'd0), .A1(16'd0), .A2(16'd0), .A3(16'd0)) u_zero
      (.clk(clk), .rst(rst), .start(start[2]), .ready(rdy[2]), .winner(win[2]), .winner_value(wv[2]));
   maxnet #(.A0(16'd1000), .A1(16'd40000), .A2(16'd39000), .A3(16'd5), .EPS(8'd60), .MAX_ITER(8'd20)) u_mix
      (.clk(clk), .rst(rst), .start(start[3]), .ready(rdy[3]), .winner(win[3]), .winner_value(wv[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference: iterate the inhibition rule with integer arithmetic until termination.
   function automatic void model(input int i0, input int i1, input int i2, input int i3,
                                 input int eps, input int maxit,
                                 output int n, output int w, output int v);
      int a [4];
      int nx [4];
      int tot;
      int nz;
      bit stop;
      a = '{i0, i1, i2, i3};
      n = 0;
      stop = 1'b0;
      while (!stop) begin
         tot = a[0] + a[1] + a[2] + a[3];
         for (int j = 0; j < 4; j++) begin
            nx[j] = a[j] - (eps * (tot - a[j])) / 256;
            if (nx[j] < 0) nx[j] = 0;
         end
         a = nx;
         n++;
         nz = 0;
         foreach (a[j]) if (a[j] != 0) nz++;
         stop = (nz <= 1) || (n == maxit);
      end
      w = 0;
      for (int j = 1; j < 4; j++) if (a[j] > a[w]) w = j;
      v = a[w];
   endfunction

   // One run on instance idx; spur>0 raises a spurious start after edge spur.
   task automatic run(input int idx, input int spur, input string tag);
      int e;
      int first;
      first = -1;
      e = 0;
      @(negedge clk) start[idx] = 1'b1;
      @(negedge clk) start[idx] = 1'b0;
      while (first < 0 && e < exp_n[idx] + 40) begin
         @(posedge clk);
         e++;
         #1;
         if (e == 1) check({tag, "_load_ready"}, rdy[idx], 0);
         if (rdy[idx] && first < 0) first = e;
         if (spur > 0 && e == spur) start[idx] = 1'b1;
         else start[idx] = 1'b0;
      end
      start[idx] = 1'b0;
      check({tag, "_done_edge"}, first, 1 + exp_n[idx]);
      check({tag, "_winner"}, win[idx], exp_w[idx]);
      check({tag, "_value"}, wv[idx], exp_v[idx]);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_hold_ready"}, rdy[idx], 1);
      check({tag, "_hold_value"}, wv[idx], exp_v[idx]);
   endtask

   initial begin
      model(51, 102, 154, 205, 51, 255, exp_n[0], exp_w[0], exp_v[0]);
      model(205, 205, 0, 0, 51, 255, exp_n[1], exp_w[1], exp_v[1]);
      model(0, 0, 0, 0, 51, 255, exp_n[2], exp_w[2], exp_v[2]);
      model(1000, 40000, 39000, 5, 60, 20, exp_n[3], exp_w[3], exp_v[3]);

      rst   = 1'b1;
      start = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         check("rst_ready", rdy[i], 0);
         check("rst_winner", win[i], 0);
         check("rst_value", wv[i], 0);
      end
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) check("idle_ready", rdy[i], 0);

      run(0, 0, "default");
      #200;
      run(0, 0, "restart");
      run(0, $urandom_range(1, exp_n[0]), "start_ignored");
      run(1, 0, "tie");
      run(2, 0, "zero");
      run(3, $urandom_range(1, exp_n[3]), "mix");

      @(negedge clk) start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < NI; i++) check("midrst_ready", rdy[i], 0);
      check("midrst_winner", win[0], 0);
      check("midrst_value", wv[0], 0);
      repeat (10) @(posedge clk);
      #1 check("midrst_idle", rdy[0], 0);
      run(0, 0, "post_rst");

      repeat (6) begin
         int idx;
         int spur;
         idx  = $urandom_range(0, NI - 1);
         spur = ($urandom_range(0, 1) == 1) ? $urandom_range(1, exp_n[idx]) : 0;
         repeat ($urandom_range(0, 5)) @(posedge clk);
         run(idx, spur, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
